// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: transmitter/receiver FSM state
// encoding and the frame parity function.
package serial_pkg;

  // Widest word the parity helper handles; narrower words are zero-extended.
  localparam int unsigned MAX_WORD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } serial_state_e;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [MAX_WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter. Counts clock cycles while enabled and flags the last
// cycle of each CLKS_PER_BIT-long bit period.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : count while high; counter held at zero while low
//   tick       : high on the last cycle of each bit period
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear when idle, wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: frames a parallel word as start(0), WIDTH data bits
// LSB first, even parity, stop(1), each bit CLKS_PER_BIT cycles long.
//   clk, reset : clock, asynchronous active-high reset
//   data_in    : word to send, captured on the accepting edge
//   valid      : data_in offered; accepted when ready is high
//   ready      : idle and able to accept a word
//   tx         : serial line, idle high
//   busy       : frame in progress (~ready)
//   done       : one-cycle pulse in the first idle cycle after the stop bit
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             tick;

  // Bit timer runs only while a frame is on the line.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk   (clk),
    .reset (reset),
    .enable(state_q != ST_IDLE),
    .tick  (tick)
  );

  // Next-state and registered-output logic; tx_d is the level for the next bit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          state_d   = ST_START;
          shift_d   = data_in;
          parity_d  = even_parity(MAX_WORD_W'(data_in));
          bit_idx_d = '0;
          tx_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_PARITY;
            tx_d    = parity_q;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = ~ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: frame contents, timing, back-to-back frames,
// ignored valid while busy, mid-frame reset, CLKS_PER_BIT=1 and WIDTH=1.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic [0:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;
  logic       ready_c, tx_c, busy_c, done_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .reset(rst), .data_in(data_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .reset(rst), .data_in(data_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut_c (
    .clk(clk), .reset(rst), .data_in(data_c), .valid(valid_c),
    .ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on dut_a and checks every cycle of the frame plus the done
  // cycle. seq[k] is the k-th line bit (k=0 start ... k=10 stop). Entered and
  // left at #1 after an edge with the DUT idle.
  task automatic frame_a(input logic [7:0] word, input logic [10:0] seq,
                         input string tag, input int inject_at, input bit hold_valid);
    chk({tag, "_ready"}, 32'(ready_a), 32'd1);
    data_a  = word;
    valid_a = 1'b1;
    step();
    valid_a = hold_valid;
    data_a  = hold_valid ? word : ~word;
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k * 4 + c == inject_at) begin
          valid_a = 1'b1;
          data_a  = 8'h3C;
        end else if (inject_at >= 0 && k * 4 + c == inject_at + 1) begin
          valid_a = 1'b0;
        end
        chk($sformatf("%s_tx%0d", tag, k * 4 + c), 32'(tx_a), 32'(seq[k]));
        chk($sformatf("%s_busy%0d", tag, k * 4 + c), 32'(busy_a), 32'd1);
        chk($sformatf("%s_done%0d", tag, k * 4 + c), 32'(done_a), 32'd0);
        step();
      end
    end
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_done_ready"}, 32'(ready_a), 32'd1);
    chk({tag, "_done_tx"}, 32'(tx_a), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a  = '0;   data_b  = '0;   data_c  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    chk("rst_tx_c", 32'(tx_c), 32'd1);
    rst = 1'b0;
    step();

    // A5: four ones, parity 0.
    frame_a(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, "a5", -1, 1'b0);
    step();
    chk("a5_done_once", 32'(done_a), 32'd0);

    // 07: three ones, parity 1.
    frame_a(8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, "h07", -1, 1'b0);
    step();

    // 81 with a 3C offer at cycle 10 that must be ignored.
    frame_a(8'h81, {1'b1, 1'b0, 8'h81, 1'b0}, "h81", 10, 1'b0);
    step();
    chk("h81_no_refire", 32'(ready_a), 32'd1);
    chk("h81_idle_tx", 32'(tx_a), 32'd1);

    // Back-to-back: 00 with valid held, FF presented in the done cycle.
    frame_a(8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, "h00", -1, 1'b1);
    frame_a(8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, "hff", -1, 1'b0);
    step();
    chk("hff_done_once", 32'(done_a), 32'd0);

    // Reset during data bit 3 of an F0 frame (that bit is 0 on the line).
    data_a  = 8'hF0;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    repeat (17) step();
    chk("rst_mid_pre_tx", 32'(tx_a), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx_a), 32'd1);
    chk("rst_mid_ready", 32'(ready_a), 32'd1);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_done", 32'(done_a), 32'd0);
    step();
    step();
    chk("rst_hold_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    frame_a(8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, "h55", -1, 1'b0);
    step();

    // CLKS_PER_BIT=1: FF gives an 11-cycle frame, parity 0, done on cycle 11.
    begin
      logic [10:0] seq_b;
      seq_b = {1'b1, 1'b0, 8'hFF, 1'b0};
      chk("b_ready", 32'(ready_b), 32'd1);
      data_b  = 8'hFF;
      valid_b = 1'b1;
      step();
      valid_b = 1'b0;
      data_b  = 8'h00;
      for (int k = 0; k < 11; k++) begin
        chk($sformatf("b_tx%0d", k), 32'(tx_b), 32'(seq_b[k]));
        chk($sformatf("b_done%0d", k), 32'(done_b), 32'd0);
        step();
      end
      chk("b_done", 32'(done_b), 32'd1);
      chk("b_done_ready", 32'(ready_b), 32'd1);
      step();
      chk("b_done_once", 32'(done_b), 32'd0);
    end

    // WIDTH=1, CLKS_PER_BIT=1: word 1 -> start 0, data 1, parity 1, stop 1.
    begin
      logic [3:0] seq_c;
      seq_c = 4'b1110;
      chk("c_ready", 32'(ready_c), 32'd1);
      data_c  = 1'b1;
      valid_c = 1'b1;
      step();
      valid_c = 1'b0;
      data_c  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("c_tx%0d", k), 32'(tx_c), 32'(seq_c[k]));
        chk($sformatf("c_busy%0d", k), 32'(busy_c), 32'd1);
        step();
      end
      chk("c_done", 32'(done_c), 32'd1);
      chk("c_done_tx", 32'(tx_c), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame (>=1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to send.
REQ-006 SHALL have port valid  input  1  data_in presented for transmission.
REQ-007 SHALL have port ready  output  1  transmitter can accept a word this cycle.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL accept a word on a rising edge where valid && ready; data_in captured into an internal shift register on that edge.
REQ-012 SHALL assert ready only in IDLE; busy SHALL equal ~ready.
REQ-013 SHALL ignore valid while busy (no capture, no frame disturbance).
REQ-014 SHALL send frame: start bit 0, WIDTH data bits LSB first, even-parity bit, stop bit 1.
REQ-015 SHALL drive tx from a register; start bit SHALL appear the cycle after the accepting edge.
REQ-016 SHALL hold each bit exactly CLKS_PER_BIT cycles; frame length (WIDTH+3)*CLKS_PER_BIT cycles.
REQ-017 SHALL implement FSM IDLE->START->DATA->PARITY->STOP->IDLE; each transition when the bit-period counter reaches CLKS_PER_BIT-1; DATA->PARITY after bit index WIDTH-1.
REQ-018 SHALL compute parity as XOR of the captured word (even total ones including the parity bit).
REQ-019 SHALL pulse done high for exactly the first IDLE cycle after STOP; ready is also high in that cycle.
REQ-020 SHALL accept valid in the done cycle, giving back-to-back frames with no idle gap between stop and next start.
REQ-021 SHALL be unaffected by data_in changes after capture.
REQ-022 SHALL operate correctly with CLKS_PER_BIT=1 and WIDTH=1.

Reset
REQ-023 SHALL, on reset asserted, immediately force: state IDLE, tx=1, ready=1, busy=0, done=0, counters and shift register 0.
REQ-024 SHALL abort a frame when reset asserts mid-frame; no done pulse; no frame resumption after release.
REQ-025 SHALL accept a new word on the first edge after reset deassertion if valid is high.

Structure
REQ-026 SHALL place FSM state encodings (IDLE, START, DATA, PARITY, STOP) and the parity function in shared package serial_pkg, for reuse by a future serial_rx.
REQ-027 SHALL implement the bit-period counter as sub-module baud_tick_gen (parameter CLKS_PER_BIT; inputs clk, reset, enable; output tick on the last cycle of each bit period).

Verification (WIDTH=8, CLKS_PER_BIT=4 unless stated)
REQ-028 SHALL cover: send 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; done pulses 44 cycles after accept.
REQ-029 SHALL cover: send 8'h07 -> parity bit 1; data bits 1,1,1,0,0,0,0,0.
REQ-030 SHALL cover: valid held high with 8'h00 then 8'hFF presented at done cycle -> second start bit directly after first stop bit; no gap.
REQ-031 SHALL cover: valid pulsed with 8'h3C at cycle 10 of an 8'h81 frame -> ignored; line carries only 8'h81 frame.
REQ-032 SHALL cover: reset asserted during DATA bit 3 -> tx=1, ready=1 asynchronously; no done; next accepted word 8'h55 transmitted correctly.
REQ-033 SHALL cover: CLKS_PER_BIT=1, send 8'hFF -> 11-cycle frame, parity 0, done on cycle 11.
